mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage controller of the pipelined MIPS core. It sits between the EX/MEM latch and the M/WB latch. It issues data-cache read/write requests for the instruction in the memory stage and holds them until `dhit`. While a request is outstanding it stalls the upstream pipeline, and it implements the LL/SC link register with coherence-snoop invalidation. It produces the load data and capture enable consumed by the M/WB latch.

## Interface
Parameters:
- `WORD_W`, 32: data and address width.

Ports:
- `CLK` in 1: clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `ex_valid` in 1: EX/MEM latch holds a live instruction.
- `ex_dren` / `ex_dwen` in 1: instruction reads / writes data memory.
- `ex_ll` / `ex_sc` in 1: instruction is LL / SC. LL also asserts `ex_dren`; SC also asserts `ex_dwen`.
- `ex_addr` in WORD_W: effective address (ALU portO).
- `ex_store` in WORD_W: store data.
- `ex_halt` in 1: HALT instruction.
- `flush` in 1: squash the memory-stage instruction (from the hazard unit).
- `dhit` in 1: cache completed the current request.
- `dmemload` in WORD_W: cache read data, valid when `dhit`.
- `snoop_valid` in 1: coherence invalidation observed this cycle.
- `snoop_addr` in WORD_W: invalidated address.
- `dmemREN` / `dmemWEN` out 1: cache read / write request.
- `dmemaddr` out WORD_W: request address.
- `dmemstore` out WORD_W: request write data.
- `mem_stall` out 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- `wb_valid` out 1: M/WB capture enable; memory stage finished this cycle.
- `wb_load` out WORD_W: value for M/WB `dmemLoad`.
- `halt_out` out 1: sticky halt.

## Operation
- States: IDLE, WAIT, HALTED. Registers: `req_addr`, `req_data`, `req_rd`, `req_wr`, `req_ll`, `req_sc`, `squash`, `link_valid`, `link_addr`.
- Memory op means `ex_valid & (ex_dren | ex_dwen)`, excluding a failing SC.
- IDLE, memory op, no `flush`:
  - Drive the request combinationally from the `ex_*` inputs and capture the `req_*` registers.
  - If `dhit` is asserted the same cycle: complete with `wb_valid`=1 and stay in IDLE.
  - Otherwise: `mem_stall`=1 and go to WAIT.
- IDLE, valid non-memory instruction: `wb_valid`=1, `wb_load`=0, no request, no stall.
- WAIT: drive the request from the `req_*` registers and keep `mem_stall`=1.
  - On `dhit`: complete, `mem_stall`=0, go to IDLE.
- Completion values:
  - Read: `wb_load`=`dmemload`.
  - Plain store: `wb_load`=0.
  - SC success: `wb_load`=1.
- SC check is made in IDLE: success requires `link_valid` and `link_addr[31:2]==ex_addr[31:2]`.
  - Fail: no request; complete immediately with `wb_load`=0, `wb_valid`=1, `link_valid`←0.
  - Success: issue a write; on completion `link_valid`←0.
- LL completion: `link_valid`←1, `link_addr`←request address.
- Plain store completion to the linked word: `link_valid`←0.
- Snoop: `snoop_valid & link_valid & snoop_addr[31:2]==link_addr[31:2]` sets `link_valid`←0.
  - Snoop coinciding with the SC check in IDLE: the snoop wins and the SC fails.
  - Snoop coinciding with LL completion: the LL set wins.
- `flush` in IDLE: no request, `wb_valid`=0.
- `flush` in WAIT: `squash`←1.
  - The request continues until `dhit`, because a cache transaction cannot be withdrawn.
  - At that completion: `wb_valid`=0, no link update; `squash` clears on return to IDLE.
- Halt: `ex_valid & ex_halt` in IDLE with no `flush` gives `wb_valid`=1 and moves to HALTED.
  - HALTED: `halt_out`=1 and no requests until reset; `mem_stall`=0.

## Timing
- Reset values: state IDLE, `link_valid`=0, `link_addr`=0, `squash`=0, `req_*`=0, `halt_out`=0. All combinational outputs are 0 in IDLE with `ex_valid`=0.
- Latency:
  - Hit in the issue cycle: 0 stall cycles.
  - Otherwise: stall for N cycles, where `dhit` arrives N cycles after issue; completion is in the `dhit` cycle.
- `dmemREN` and `dmemWEN` are never both 1. Request signals are stable from issue through `dhit`.
- `mem_stall` deasserts in the `dhit` cycle, so the next instruction enters the following cycle.
- `nRST` asserted in WAIT abandons the request immediately and clears the link.

## Test plan
- LW at 0x100, `dhit` after 3 cycles with `dmemload`=0xDEADBEEF → `mem_stall` high for 3 cycles, `dmemREN` high for 4, one `wb_valid` pulse with `wb_load`=0xDEADBEEF.
- SW at 0x40, data 0x1234, `dhit` in the issue cycle → `dmemWEN`=1 and `wb_valid`=1 the same cycle, no stall.
- LL 0x80, then SC 0x80 → SC writes and `wb_load`=1. A second SC to 0x80 → no request, `wb_load`=0.
- LL 0x80, snoop 0x84 (no effect), snoop 0x80, then SC 0x80 → SC fails, `dmemWEN` never asserted.
- LW in WAIT, `flush` pulse, `dhit` 2 cycles later → the request holds until `dhit`, `wb_valid` stays 0, the next instruction proceeds.
- HALT with `ex_valid` → `halt_out`=1. A subsequent LW with `ex_valid` produces no `dmemREN`. Asserting `nRST` returns all outputs to 0.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage data-cache request control with stall, LL/SC link register and snoop invalidation
module mem_stage_ctrl #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ex_valid,
    input  logic              ex_dren,
    input  logic              ex_dwen,
    input  logic              ex_ll,
    input  logic              ex_sc,
    input  logic [WORD_W-1:0] ex_addr,
    input  logic [WORD_W-1:0] ex_store,
    input  logic              ex_halt,
    input  logic              flush,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              snoop_valid,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              wb_valid,
    output logic [WORD_W-1:0] wb_load,
    output logic              halt_out
);
    typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;

    state_t            state, state_n;
    logic [WORD_W-1:0] req_addr, req_data, link_addr, link_addr_n;
    logic              req_rd, req_wr, req_ll, req_sc;
    logic              squash, squash_n, link_valid, link_valid_n;
    logic              snoop_kill, sc_ok, sc_fail, mem_op, issue, active, done;
    logic [WORD_W-1:0] c_addr, c_data;
    logic              c_rd, c_wr, c_ll, c_sc;
    logic              unused_ok;

    // Snoop on the linked word always beats an SC check made in the same cycle
    assign snoop_kill = snoop_valid & link_valid & (snoop_addr[WORD_W-1:2] == link_addr[WORD_W-1:2]);
    assign sc_ok      = link_valid & ~snoop_kill & (link_addr[WORD_W-1:2] == ex_addr[WORD_W-1:2]);
    assign sc_fail    = ex_valid & ex_sc & ~sc_ok;
    assign mem_op     = ex_valid & (ex_dren | ex_dwen) & ~sc_fail;
    assign halt_out   = (state == HALTED);
    assign unused_ok  = ^snoop_addr[1:0];

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    // Next state, request drive and completion; c_* describe the request in flight this cycle
    always_comb begin
        state_n   = state;
        squash_n  = squash;
        issue     = 1'b0;
        done      = 1'b0;
        mem_stall = 1'b0;
        wb_valid  = 1'b0;
        c_addr    = req_addr;
        c_data    = req_data;
        c_rd      = req_rd;
        c_wr      = req_wr;
        c_ll      = req_ll;
        c_sc      = req_sc;
        case (state)
            IDLE: begin
                squash_n = 1'b0;
                if (ex_valid && !flush) begin
                    if (mem_op) begin
                        issue  = 1'b1;
                        c_addr = ex_addr;
                        c_data = ex_store;
                        c_rd   = ex_dren & ~ex_dwen;
                        c_wr   = ex_dwen;
                        c_ll   = ex_ll;
                        c_sc   = ex_sc;
                        if (dhit) begin
                            done     = 1'b1;
                            wb_valid = 1'b1;
                        end else begin
                            mem_stall = 1'b1;
                            state_n   = WAIT;
                        end
                    end else begin
                        wb_valid = 1'b1;
                        state_n  = ex_halt ? HALTED : IDLE;
                    end
                end
            end
            WAIT: begin
                mem_stall = ~dhit;
                squash_n  = dhit ? 1'b0 : (squash | flush);
                done      = dhit & ~squash & ~flush;
                wb_valid  = done;
                state_n   = dhit ? IDLE : WAIT;
            end
            HALTED: state_n = HALTED;
            default: state_n = IDLE;
        endcase
        active    = issue | (state == WAIT);
        dmemREN   = active & c_rd;
        dmemWEN   = active & c_wr;
        dmemaddr  = active ? c_addr : '0;
        dmemstore = (active & c_wr) ? c_data : '0;
        wb_load   = !done ? '0 : c_rd ? dmemload : c_sc ? WORD_W'(1) : '0;
    end

    // Link register update; an LL completing in the same cycle as a snoop keeps the new link
    always_comb begin
        link_valid_n = link_valid;
        link_addr_n  = link_addr;
        if (snoop_kill) link_valid_n = 1'b0;
        if (state == IDLE && ex_valid && !flush && sc_fail) link_valid_n = 1'b0;
        if (done && c_wr && (c_sc || c_addr[WORD_W-1:2] == link_addr[WORD_W-1:2])) link_valid_n = 1'b0;
        if (done && c_ll) begin
            link_valid_n = 1'b1;
            link_addr_n  = c_addr;
        end
    end

    // Request capture at issue, squash tracking and link state
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_addr   <= '0;
            req_data   <= '0;
            req_rd     <= 1'b0;
            req_wr     <= 1'b0;
            req_ll     <= 1'b0;
            req_sc     <= 1'b0;
            squash     <= 1'b0;
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            if (issue) begin
                req_addr <= c_addr;
                req_data <= c_data;
                req_rd   <= c_rd;
                req_wr   <= c_wr;
                req_ll   <= c_ll;
                req_sc   <= c_sc;
            end
            squash     <= squash_n;
            link_valid <= link_valid_n;
            link_addr  <= link_addr_n;
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed vector table plus hand sequences for flush, halt and reset
module tb_mem_stage_ctrl;
    localparam logic [8:0] V = 9'd1, RD = 9'd2, WR = 9'd4, LL = 9'd8, SC = 9'd16,
                           HT = 9'd32, FL = 9'd64, HIT = 9'd128, SNP = 9'd256;
    localparam logic [4:0] XR = 5'd1, XW = 5'd2, XS = 5'd4, XB = 5'd8, XH = 5'd16;

    typedef struct {
        logic [8:0]  c;
        logic [31:0] a, st, ld, sa;
        logic [4:0]  x;
        logic [31:0] el;
    } vec_t;

    logic        CLK = 1'b0, nRST = 1'b0;
    logic        ex_valid, ex_dren, ex_dwen, ex_ll, ex_sc, ex_halt, flush, dhit, snoop_valid;
    logic [31:0] ex_addr, ex_store, dmemload, snoop_addr;
    logic        dmemREN, dmemWEN, mem_stall, wb_valid, halt_out;
    logic [31:0] dmemaddr, dmemstore, wb_load;
    int          n_chk = 0, n_fail = 0;
    vec_t        vq[$];

    always #5 CLK = ~CLK;

    mem_stage_ctrl #(.WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_dren(ex_dren), .ex_dwen(ex_dwen),
        .ex_ll(ex_ll), .ex_sc(ex_sc), .ex_addr(ex_addr), .ex_store(ex_store), .ex_halt(ex_halt),
        .flush(flush), .dhit(dhit), .dmemload(dmemload), .snoop_valid(snoop_valid),
        .snoop_addr(snoop_addr), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_load(wb_load),
        .halt_out(halt_out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [8:0] c, input logic [31:0] a, st, ld, sa);
        ex_valid = c[0]; ex_dren = c[1]; ex_dwen = c[2]; ex_ll = c[3]; ex_sc = c[4];
        ex_halt = c[5]; flush = c[6]; dhit = c[7]; snoop_valid = c[8];
        ex_addr = a; ex_store = st; dmemload = ld; snoop_addr = sa;
    endtask

    task automatic check_out(input string tag, input logic [4:0] x, input logic [31:0] ea, es, el);
        chk({tag, " dmemREN"}, 32'(dmemREN), 32'(x[0]));
        chk({tag, " dmemWEN"}, 32'(dmemWEN), 32'(x[1]));
        chk({tag, " mem_stall"}, 32'(mem_stall), 32'(x[2]));
        chk({tag, " wb_valid"}, 32'(wb_valid), 32'(x[3]));
        chk({tag, " halt_out"}, 32'(halt_out), 32'(x[4]));
        chk({tag, " dmemaddr"}, dmemaddr, ea);
        chk({tag, " dmemstore"}, dmemstore, es);
        chk({tag, " wb_load"}, wb_load, el);
    endtask

    task automatic step(input string tag, input logic [8:0] c, input logic [31:0] a, st, ld, sa,
                        input logic [4:0] x, input logic [31:0] ea, es, el);
        @(negedge CLK);
        drive(c, a, st, ld, sa);
        #1 check_out(tag, x, ea, es, el);
    endtask

    task automatic add(input logic [8:0] c, input logic [31:0] a, st, ld, sa,
                       input logic [4:0] x, input logic [31:0] el);
        vec_t t;
        t.c = c; t.a = a; t.st = st; t.ld = ld; t.sa = sa; t.x = x; t.el = el;
        vq.push_back(t);
    endtask

    initial begin
        drive(9'd0, 0, 0, 0, 0);
        repeat (2) @(negedge CLK);
        #1 check_out("reset", 5'd0, 0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;
        add(9'd0,            32'h000, 0,      0,            0,     5'd0,     0);
        add(V|RD,            32'h100, 0,      0,            0,     XR|XS,    0);
        add(V|RD,            32'h100, 0,      0,            0,     XR|XS,    0);
        add(V|RD,            32'h100, 0,      0,            0,     XR|XS,    0);
        add(V|RD|HIT,        32'h100, 0,      32'hDEADBEEF, 0,     XR|XB,    32'hDEADBEEF);
        add(V|WR|HIT,        32'h040, 32'h1234, 0,          0,     XW|XB,    0);
        add(V,               32'h999, 32'h77, 0,            0,     XB,       0);
        add(V|RD|LL|HIT,     32'h080, 0,      32'h55,       0,     XR|XB,    32'h55);
        add(V|WR|SC|HIT,     32'h080, 32'h7,  0,            0,     XW|XB,    1);
        add(V|WR|SC|HIT,     32'h080, 32'h7,  0,            0,     XB,       0);
        add(V|RD|LL|HIT,     32'h080, 0,      32'h11,       0,     XR|XB,    32'h11);
        add(SNP,             32'h000, 0,      0,            32'h84, 5'd0,    0);
        add(V|WR|SC,         32'h080, 32'h9,  0,            0,     XW|XS,    0);
        add(V|WR|SC|HIT,     32'h080, 32'h9,  0,            0,     XW|XB,    1);
        add(V|RD|LL|HIT,     32'h080, 0,      32'h22,       0,     XR|XB,    32'h22);
        add(SNP,             32'h000, 0,      0,            32'h80, 5'd0,    0);
        add(V|WR|SC,         32'h080, 32'h9,  0,            0,     XB,       0);
        add(V|RD|LL|HIT,     32'h080, 0,      32'h33,       0,     XR|XB,    32'h33);
        add(V|WR|SC|HIT|SNP, 32'h080, 32'h9,  0,            32'h80, XB,      0);
        add(V|RD|LL|HIT|SNP, 32'h080, 0,      32'h44,       32'h80, XR|XB,   32'h44);
        add(V|WR|SC|HIT,     32'h080, 32'hA,  0,            0,     XW|XB,    1);
        add(V|RD|LL|HIT,     32'h080, 0,      32'h0,        0,     XR|XB,    0);
        add(V|WR|HIT,        32'h088, 32'h5,  0,            0,     XW|XB,    0);
        add(V|WR|SC|HIT,     32'h083, 32'hB,  0,            0,     XW|XB,    1);
        add(V|RD|LL|HIT,     32'h080, 0,      32'h66,       0,     XR|XB,    32'h66);
        add(V|WR|HIT,        32'h080, 32'h6,  0,            0,     XW|XB,    0);
        add(V|WR|SC|HIT,     32'h080, 32'hC,  0,            0,     XB,       0);
        add(V|RD|FL|HIT,     32'h100, 0,      32'h12,       0,     5'd0,     0);
        foreach (vq[i])
            step($sformatf("v%0d", i), vq[i].c, vq[i].a, vq[i].st, vq[i].ld, vq[i].sa, vq[i].x,
                 (vq[i].x & (XR|XW)) != 0 ? vq[i].a : 32'h0, vq[i].x[1] ? vq[i].st : 32'h0, vq[i].el);
        step("fl_issue", V|RD,     32'h200, 0, 0,            0, XR|XS, 32'h200, 0, 0);
        step("fl_pulse", V|RD|FL,  32'h999, 0, 0,            0, XR|XS, 32'h200, 0, 0);
        step("fl_hold",  V|RD,     32'h999, 0, 0,            0, XR|XS, 32'h200, 0, 0);
        step("fl_hit",   V|RD|HIT, 32'h999, 0, 32'hDEADBEEF, 0, XR,    32'h200, 0, 0);
        step("fl_next",  V,        32'h000, 0, 0,            0, XB,    0,       0, 0);
        step("halt",     V|HT,     32'h000, 0, 0,            0, XB,    0,       0, 0);
        step("halted_lw", V|RD|HIT, 32'h100, 0, 32'h5,       0, XH,    0,       0, 0);
        @(negedge CLK);
        drive(9'd0, 0, 0, 0, 0);
        nRST = 1'b0;
        #1 check_out("halt_rst", 5'd0, 0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;
        step("w_ll",     V|RD|LL|HIT, 32'h080, 0, 32'h77, 0, XR|XB, 32'h080, 0, 32'h77);
        step("w_lw",     V|RD,        32'h300, 0, 0,      0, XR|XS, 32'h300, 0, 0);
        @(negedge CLK);
        drive(9'd0, 0, 0, 0, 0);
        nRST = 1'b0;
        #1 check_out("wait_rst", 5'd0, 0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;
        step("post_idle", 9'd0,        32'h000, 0, 0, 0, 5'd0, 0, 0, 0);
        step("post_sc",   V|WR|SC|HIT, 32'h080, 32'hD, 0, 0, XB, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
